// File: rtl/mult_control_pkg.sv
// Shared definitions for the shift-add multiplier sequencer.
//   SIZE_DATA      default operand width, which is also the iteration count
//   state_t        2-bit sequencer state encoding
//   *_LOAD/_SHIFT  datapath mux select values driven by mult_control
package mult_control_pkg;

  localparam int SIZE_DATA = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  // A register mux
  localparam logic A_LOAD   = 1'b0;
  localparam logic A_SHIFT  = 1'b1;
  // B register mux
  localparam logic B_LOAD   = 1'b0;
  localparam logic B_SHIFT  = 1'b1;
  // Product register mux
  localparam logic PROD_CLR = 1'b0;
  localparam logic PROD_ADD = 1'b1;
  // Adder bypass mux
  localparam logic ADD_HOLD = 1'b0;
  localparam logic ADD_ACC  = 1'b1;

endpackage

// File: rtl/mult_control_iter_cnt.sv
// mult_iter_cnt: iteration counter for the multiplier sequencer.
// Ports:
//   clk, reset  clock, async active-high reset
//   clr         zero the count (takes priority over inc)
//   inc         advance the count; saturates at LAST so it never wraps
//   term        count has reached LAST
module mult_iter_cnt #(
  parameter int WIDTH = 6,
  parameter int LAST  = 31
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic term
);

  logic [WIDTH-1:0] cnt;

  assign term = (cnt == WIDTH'(LAST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             cnt <= '0;
    else if (clr)          cnt <= '0;
    else if (inc && !term) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/mult_control.sv
// mult_control: Moore sequencer for the shift-add multiplier datapath.
// One LOAD cycle, then `size` add/shift iterations, then done is held until
// start drops.
// Ports:
//   clk, reset   clock, async active-high reset
//   start        request, sampled in IDLE
//   b_lsb        LSB of the datapath's B-mux output (next B value)
//   abort        cancel LOAD/ITER (present only with MULT_ABORT_EN defined)
//   a_sel/b_sel  0 load operand, 1 shift
//   prod_sel     0 clear product, 1 take adder mux
//   add_sel      0 hold product, 1 product + A
//   busy         high in LOAD and ITER
//   done         high in DONE; product valid
// Build option: MULT_ABORT_EN adds the abort input.
module mult_control
  import mult_control_pkg::*;
#(
  parameter int size = SIZE_DATA
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic b_lsb,
`ifdef MULT_ABORT_EN
  input  logic abort,
`endif
  output logic a_sel,
  output logic b_sel,
  output logic prod_sel,
  output logic add_sel,
  output logic busy,
  output logic done
);

  localparam int CNT_W = $clog2(size) + 1;

  state_t state, nextState;
  logic   bQ;
  logic   cntTerm;
  logic   abortReq;

`ifdef MULT_ABORT_EN
  assign abortReq = abort;
`else
  assign abortReq = 1'b0;
`endif

  mult_iter_cnt #(
    .WIDTH (CNT_W),
    .LAST  (size - 1)
  ) uCnt (
    .clk   (clk),
    .reset (reset),
    .clr   (state == LOAD),
    .inc   (state == ITER),
    .term  (cntTerm)
  );

  // b_lsb is the next B value, so registering it gives the current regB[0]
  // in step with the product add.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bQ <= 1'b0;
    else       bQ <= b_lsb;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (start) nextState = LOAD;
      LOAD: nextState = abortReq ? IDLE : ITER;
      ITER: begin
        if (abortReq)     nextState = IDLE;
        else if (cntTerm) nextState = DONE;
      end
      DONE: if (!start) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Moore decode: state and bQ only, so start never reaches an output.
  always_comb begin
    a_sel    = A_LOAD;
    b_sel    = B_LOAD;
    prod_sel = PROD_ADD;
    add_sel  = ADD_HOLD;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: ;
      LOAD: begin
        prod_sel = PROD_CLR;
        busy     = 1'b1;
      end
      ITER: begin
        a_sel   = A_SHIFT;
        b_sel   = B_SHIFT;
        add_sel = bQ;
        busy    = 1'b1;
      end
      DONE: begin
        a_sel = A_SHIFT;
        b_sel = B_SHIFT;
        done  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_control.sv
// Bench for mult_control with a behavioural shift-add datapath (size=32).
module tb_mult_control;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        b_lsb;
  logic        a_sel, b_sel, prod_sel, add_sel, busy, done;
  logic [31:0] a32 = '0, b32 = '0;
  logic [63:0] regA, prod;
  logic [31:0] regB, bMux;

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  mult_control dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .b_lsb    (b_lsb),
`ifdef MULT_ABORT_EN
    .abort    (abort),
`endif
    .a_sel    (a_sel),
    .b_sel    (b_sel),
    .prod_sel (prod_sel),
    .add_sel  (add_sel),
    .busy     (busy),
    .done     (done)
  );

  // Datapath model
  assign bMux  = b_sel ? (regB >> 1) : b32;
  assign b_lsb = bMux[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regA <= '0;
      regB <= '0;
      prod <= '0;
    end else begin
      regA <= a_sel ? (regA << 1) : {32'd0, a32};
      regB <= bMux;
      prod <= !prod_sel ? 64'd0 : (add_sel ? prod + regA : prod);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one multiply; edges counts rising edges from the start-sample edge
  // through the edge after which done is seen. adds counts add_sel=1 cycles.
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                         input bit keepStart, output int edges, output int adds);
    a32 = a;
    b32 = b;
    start = 1'b1;
    tick();
    edges = 1;
    adds  = 0;
    while (!done && edges < 100) begin
      if (add_sel) adds++;
      tick();
      edges++;
    end
    if (!keepStart) begin
      start = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    nChecks++; if (busy !== 1'b0)     begin nFails++; $display("FAIL reset_busy got %b want 0", busy); end
    nChecks++; if (done !== 1'b0)     begin nFails++; $display("FAIL reset_done got %b want 0", done); end
    nChecks++; if (a_sel !== 1'b0)    begin nFails++; $display("FAIL reset_a_sel got %b want 0", a_sel); end
    nChecks++; if (b_sel !== 1'b0)    begin nFails++; $display("FAIL reset_b_sel got %b want 0", b_sel); end
    nChecks++; if (prod_sel !== 1'b1) begin nFails++; $display("FAIL reset_prod_sel got %b want 1", prod_sel); end
    nChecks++; if (add_sel !== 1'b0)  begin nFails++; $display("FAIL reset_add_sel got %b want 0", add_sel); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int edges, adds;
    a32 = 32'd3;
    b32 = 32'd5;
    start = 1'b1;
    tick();
    // now in LOAD
    nChecks++; if (busy !== 1'b1 || prod_sel !== 1'b0)
      begin nFails++; $display("FAIL load_outputs got busy=%b prod_sel=%b want 1/0", busy, prod_sel); end
    start = 1'b0;
    edges = 1;
    adds  = 0;
    while (!done && edges < 100) begin
      tick();
      edges++;
    end
    nChecks++; if (edges !== 34) begin nFails++; $display("FAIL basic_latency got %0d want 34", edges); end
    nChecks++; if (prod !== 64'd15) begin nFails++; $display("FAIL basic_prod got %h want 15", prod); end
    tick();
    nChecks++; if (done !== 1'b0) begin nFails++; $display("FAIL basic_done_drop got %b want 0", done); end
  endtask

  task automatic test_all_ones();
    int edges, adds;
    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, edges, adds);
    nChecks++; if (prod !== 64'hFFFF_FFFE_0000_0001)
      begin nFails++; $display("FAIL ones_prod got %h want fffffffe00000001", prod); end
    nChecks++; if (adds !== 32) begin nFails++; $display("FAIL ones_adds got %0d want 32", adds); end
  endtask

  task automatic test_zero_and_msb();
    int edges, adds;
    do_mult(32'h1234, 32'd0, 1'b0, edges, adds);
    nChecks++; if (adds !== 0) begin nFails++; $display("FAIL zero_adds got %0d want 0", adds); end
    nChecks++; if (prod !== 64'd0) begin nFails++; $display("FAIL zero_prod got %h want 0", prod); end
    do_mult(32'd7, 32'h8000_0000, 1'b0, edges, adds);
    nChecks++; if (prod !== 64'h3_8000_0000)
      begin nFails++; $display("FAIL msb_prod got %h want 380000000", prod); end
    nChecks++; if (adds !== 1) begin nFails++; $display("FAIL msb_adds got %0d want 1", adds); end
  endtask

  task automatic test_hold_done();
    int edges, adds;
    do_mult(32'd11, 32'd13, 1'b1, edges, adds);
    repeat (5) tick();
    nChecks++; if (done !== 1'b1) begin nFails++; $display("FAIL hold_done got %b want 1", done); end
    nChecks++; if (prod !== 64'd143) begin nFails++; $display("FAIL hold_prod got %0d want 143", prod); end
    start = 1'b0;
    tick();
    nChecks++; if (done !== 1'b0 || busy !== 1'b0)
      begin nFails++; $display("FAIL hold_release got done=%b busy=%b want 0/0", done, busy); end
    nChecks++; if (prod !== 64'd143) begin nFails++; $display("FAIL hold_idle_prod got %0d want 143", prod); end
  endtask

  task automatic test_reset_mid();
    int edges, adds;
    a32 = 32'd100;
    b32 = 32'hFFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();  // ITER cycle 10
    nChecks++; if (busy !== 1'b1) begin nFails++; $display("FAIL mid_busy_pre got %b want 1", busy); end
    reset = 1'b1;
    #1;
    nChecks++; if (busy !== 1'b0 || done !== 1'b0)
      begin nFails++; $display("FAIL mid_reset got busy=%b done=%b want 0/0", busy, done); end
    nChecks++; if (a_sel !== 1'b0 || prod_sel !== 1'b1 || add_sel !== 1'b0)
      begin nFails++; $display("FAIL mid_idle_sel got a=%b p=%b add=%b want 0/1/0", a_sel, prod_sel, add_sel); end
    nChecks++; if (prod !== 64'd0) begin nFails++; $display("FAIL mid_prod_clr got %h want 0", prod); end
    #2;
    reset = 1'b0;
    tick();
    do_mult(32'd6, 32'd7, 1'b0, edges, adds);
    nChecks++; if (prod !== 64'd42) begin nFails++; $display("FAIL after_reset_prod got %0d want 42", prod); end
  endtask

`ifdef MULT_ABORT_EN
  task automatic test_abort();
    int edges, adds;
    logic sawDone;
    a32 = 32'd9;
    b32 = 32'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();  // ITER cycle 5
    abort = 1'b1;
    tick();
    abort = 1'b0;
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("FAIL abort_busy got %b want 0", busy); end
    sawDone = 1'b0;
    repeat (40) begin
      if (done) sawDone = 1'b1;
      tick();
    end
    nChecks++; if (sawDone !== 1'b0) begin nFails++; $display("FAIL abort_done got %b want 0", sawDone); end
    do_mult(32'd2, 32'd9, 1'b0, edges, adds);
    nChecks++; if (prod !== 64'd18) begin nFails++; $display("FAIL abort_next_prod got %0d want 18", prod); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_all_ones();
    test_zero_and_msb();
    test_hold_done();
    test_reset_mid();
`ifdef MULT_ABORT_EN
    test_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
